// File: rtl/vga_layer_scheduler.sv
// vga_layer_scheduler: composites solid rectangle layers over a background.
// Layers are programmed into a shadow bank and swapped in at vblank entry.
module vga_layer_scheduler #(
    parameter int          NUM_LAYERS = 4,
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter logic [23:0] BG_COLOR   = 24'h000000
) (
    input  logic                          VGA_CLK,
    input  logic                          reset,
    input  logic                          VGA_BLANK_N,
    input  logic                          VGA_VS,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [$clog2(NUM_LAYERS)-1:0] cfg_layer,
    input  logic [9:0]                    cfg_x0,
    input  logic [9:0]                    cfg_x1,
    input  logic [9:0]                    cfg_y0,
    input  logic [9:0]                    cfg_y1,
    input  logic [23:0]                   cfg_color,
    input  logic                          cfg_enable,
    input  logic                          commit,
    output logic                          commit_pending,
    output logic                          frame_done,
    output logic [9:0]                    pix_x,
    output logic [9:0]                    pix_y,
    output logic [23:0]                   rgb_color
);
    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    typedef enum logic [1:0] {OPEN, PENDING, COPY} state_t;

    typedef struct packed {
        logic        en;
        logic [23:0] color;
        logic [9:0]  y1;
        logic [9:0]  y0;
        logic [9:0]  x1;
        logic [9:0]  x0;
    } layer_t;

    state_t      state;
    layer_t      shadow [NUM_LAYERS];
    layer_t      active [NUM_LAYERS];
    logic        blank_q;
    logic        line_end;
    logic        vblank_entry;
    logic        cfg_write;
    logic [23:0] hit_color;

    assign line_end     = blank_q & ~VGA_BLANK_N;
    assign vblank_entry = line_end && (pix_y == Y_LAST);
    assign cfg_write    = cfg_valid && cfg_ready
                          && (int'(cfg_layer) < NUM_LAYERS);

    // Scan from lowest priority upwards so layer 0 wins any overlap.
    always_comb begin
        hit_color = BG_COLOR;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (active[i].en
                && active[i].x0 <= pix_x && pix_x <= active[i].x1
                && active[i].y0 <= pix_y && pix_y <= active[i].y1)
                hit_color = active[i].color;
        end
    end

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            blank_q   <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            rgb_color <= '0;
        end else begin
            blank_q <= VGA_BLANK_N;
            if (!VGA_BLANK_N)
                pix_x <= '0;
            else if (pix_x != X_LAST)
                pix_x <= pix_x + 10'd1;
            if (!VGA_VS)
                pix_y <= '0;
            else if (line_end)
                pix_y <= pix_y + 10'd1;
            rgb_color <= VGA_BLANK_N ? hit_color : 24'h000000;
        end
    end

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            state          <= OPEN;
            cfg_ready      <= 1'b1;
            commit_pending <= 1'b0;
            frame_done     <= 1'b0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            frame_done <= vblank_entry;
            if (cfg_write)
                shadow[cfg_layer] <= {cfg_enable, cfg_color,
                                      cfg_y1, cfg_y0, cfg_x1, cfg_x0};
            unique case (state)
                OPEN: begin
                    if (commit) begin
                        state          <= PENDING;
                        cfg_ready      <= 1'b0;
                        commit_pending <= 1'b1;
                    end
                end
                PENDING: begin
                    if (vblank_entry)
                        state <= COPY;
                end
                COPY: begin
                    for (int i = 0; i < NUM_LAYERS; i++)
                        active[i] <= shadow[i];
                    commit_pending <= 1'b0;
                    cfg_ready      <= 1'b1;
                    state          <= OPEN;
                end
                default: state <= OPEN;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_layer_scheduler.sv
// tb_vga_layer_scheduler: drives a shrunken VGA raster and checks every
// cycle against a pixel-level model of the layer banks.
module tb_vga_layer_scheduler;
    localparam int NL = 4;
    localparam int HA = 32;
    localparam int VA = 24;
    localparam int HT = 40;
    localparam int VT = 28;
    localparam int FRAME = HT * VT;
    localparam logic [23:0] BG = 24'h123456;

    logic        clk = 1'b0;
    logic        reset;
    logic        VGA_BLANK_N;
    logic        VGA_VS;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_layer;
    logic [9:0]  cfg_x0;
    logic [9:0]  cfg_x1;
    logic [9:0]  cfg_y0;
    logic [9:0]  cfg_y1;
    logic [23:0] cfg_color;
    logic        cfg_enable;
    logic        commit;
    logic        commit_pending;
    logic        frame_done;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [23:0] rgb_color;

    vga_layer_scheduler #(
        .NUM_LAYERS(NL),
        .H_ACTIVE  (HA),
        .V_ACTIVE  (VA),
        .BG_COLOR  (BG)
    ) dut (
        .VGA_CLK       (clk),
        .reset         (reset),
        .VGA_BLANK_N   (VGA_BLANK_N),
        .VGA_VS        (VGA_VS),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_layer     (cfg_layer),
        .cfg_x0        (cfg_x0),
        .cfg_x1        (cfg_x1),
        .cfg_y0        (cfg_y0),
        .cfg_y1        (cfg_y1),
        .cfg_color     (cfg_color),
        .cfg_enable    (cfg_enable),
        .commit        (commit),
        .commit_pending(commit_pending),
        .frame_done    (frame_done),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .rgb_color     (rgb_color)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          x0;
        int          x1;
        int          y0;
        int          y1;
        logic [23:0] c;
        bit          en;
    } mlayer_t;

    mlayer_t     m_shadow [NL];
    mlayer_t     m_active [NL];
    bit          m_pending;
    bit          synced;
    int          hc = 0;
    int          vc = 0;
    int          s_hc;
    int          s_vc;
    logic [23:0] exp_rgb = '0;
    logic        exp_fd = 1'b0;
    logic        exp_pend = 1'b0;
    logic        exp_rdy = 1'b1;
    int          exp_px;
    int          exp_py;
    bit          chk_pix;
    int          vectors = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at line %0d col %0d",
                     name, act, exp, s_vc, s_hc);
        end
    endtask

    function automatic logic [23:0] color_at(int x, int y);
        for (int i = 0; i < NL; i++)
            if (m_active[i].en && x >= m_active[i].x0 && x <= m_active[i].x1
                && y >= m_active[i].y0 && y <= m_active[i].y1)
                return m_active[i].c;
        return BG;
    endfunction

    task automatic drive_video();
        VGA_BLANK_N = (hc < HA) && (vc < VA);
        VGA_VS      = !(vc == VA + 1 || vc == VA + 2);
    endtask

    // Expected outputs after the edge that samples the current inputs.
    task automatic model_step();
        bit vis;
        bit entry;
        bit copied;
        bit rdy_prev;
        s_hc = hc;
        s_vc = vc;
        if (reset) begin
            for (int i = 0; i < NL; i++) begin
                m_shadow[i] = '{0, 0, 0, 0, 24'h0, 1'b0};
                m_active[i] = '{0, 0, 0, 0, 24'h0, 1'b0};
            end
            m_pending = 0;
            synced    = 0;
            exp_rgb   = '0;
            exp_fd    = 1'b0;
            exp_pend  = 1'b0;
            exp_rdy   = 1'b1;
            chk_pix   = 0;
            return;
        end
        vis      = (hc < HA) && (vc < VA);
        rdy_prev = exp_rdy;
        exp_rgb  = vis ? color_at(hc, vc) : 24'h0;
        entry    = synced && hc == HA && vc == VA - 1;
        exp_fd   = entry;
        copied   = 0;
        if (entry && m_pending) begin
            m_active  = m_shadow;
            m_pending = 0;
            copied    = 1;
        end
        if (cfg_valid && rdy_prev)
            m_shadow[cfg_layer] = '{int'(cfg_x0), int'(cfg_x1),
                                    int'(cfg_y0), int'(cfg_y1),
                                    cfg_color, cfg_enable};
        if (commit && rdy_prev)
            m_pending = 1;
        exp_pend = m_pending || copied;
        exp_rdy  = !exp_pend;
        chk_pix  = synced && vis;
        exp_px   = (hc == HA - 1) ? HA - 1 : hc + 1;
        exp_py   = vc;
        if (!VGA_VS)
            synced = 1;
    endtask

    task automatic compare();
        check("rgb", rgb_color, exp_rgb);
        check("frame_done", frame_done, exp_fd);
        check("commit_pending", commit_pending, exp_pend);
        check("cfg_ready", cfg_ready, exp_rdy);
        if (chk_pix) begin
            check("pix_x", pix_x, exp_px);
            check("pix_y", pix_y, exp_py);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        hc++;
        if (hc == HT) begin
            hc = 0;
            vc = (vc == VT - 1) ? 0 : vc + 1;
        end
        drive_video();
    endtask

    task automatic wait_until(int x, int y);
        int n = 0;
        while (!(hc == x && vc == y) && n < 3 * FRAME) begin
            tick();
            n++;
        end
        if (!(hc == x && vc == y)) begin
            vectors++;
            errors++;
            $display("FAIL wait_until: position %0d,%0d not reached", x, y);
        end
    endtask

    task automatic expect_px(int x, int y, logic [23:0] lit, string name);
        int n = 1;
        tick();
        while (!(s_hc == x && s_vc == y) && n < 3 * FRAME) begin
            tick();
            n++;
        end
        if (s_hc == x && s_vc == y)
            check(name, rgb_color, lit);
        else begin
            vectors++;
            errors++;
            $display("FAIL %s: pixel %0d,%0d never sampled", name, x, y);
        end
    endtask

    task automatic cfg_write(int l, int x0, int x1, int y0, int y1,
                             logic [23:0] c, bit with_commit);
        cfg_layer  = 2'(l);
        cfg_x0     = 10'(x0);
        cfg_x1     = 10'(x1);
        cfg_y0     = 10'(y0);
        cfg_y1     = 10'(y1);
        cfg_color  = c;
        cfg_enable = 1'b1;
        cfg_valid  = 1'b1;
        commit     = with_commit;
        tick();
        cfg_valid  = 1'b0;
        commit     = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    initial begin
        int fd_cnt;
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_layer = '0;
        cfg_x0    = '0;
        cfg_x1    = '0;
        cfg_y0    = '0;
        cfg_y1    = '0;
        cfg_color = '0;
        cfg_enable = 1'b0;
        commit    = 1'b0;
        drive_video();
        wait_until(10, 2);
        reset = 1'b0;

        wait_until(20, 3);
        reset = 1'b1;
        #1;
        check("async_rst_rgb", rgb_color, 24'h0);
        check("async_rst_pix_x", pix_x, 10'd0);
        check("async_rst_pix_y", pix_y, 10'd0);
        check("async_rst_ready", cfg_ready, 1'b1);
        check("async_rst_pending", commit_pending, 1'b0);
        check("async_rst_fd", frame_done, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        expect_px(0, 0, BG, "bg_first_pixel");
        expect_px(HA, 0, 24'h0, "blank_is_zero");

        cfg_write(0, 10, 19, 5, 14, 24'hFF0000, 0);
        pulse_commit();
        check("pending_after_commit", commit_pending, 1'b1);
        check("ready_drop", cfg_ready, 1'b0);
        expect_px(15, 10, BG, "single_same_frame");
        expect_px(10, 5, 24'hFF0000, "single_top_left");
        expect_px(9, 10, BG, "single_left_out");
        expect_px(15, 10, 24'hFF0000, "single_mid");
        expect_px(19, 14, 24'hFF0000, "single_bot_right");
        expect_px(20, 14, BG, "single_right_out");
        expect_px(10, 15, BG, "single_below_out");

        cfg_write(0, 0, 9, 0, 9, 24'h00FF00, 0);
        cfg_write(1, 5, 20, 5, 20, 24'h0000FF, 1);
        check("write_commit_pending", commit_pending, 1'b1);
        expect_px(7, 7, 24'h00FF00, "prio_overlap");
        expect_px(15, 10, 24'h0000FF, "prio_old_region");
        expect_px(15, 15, 24'h0000FF, "prio_layer1");
        expect_px(25, 16, BG, "prio_bg");

        cfg_write(1, 5, 20, 5, 20, 24'hFFFF00, 1);
        check("tear_ready_low", cfg_ready, 1'b0);
        expect_px(15, 18, 24'h0000FF, "tear_old_frame");
        expect_px(15, 15, 24'hFFFF00, "tear_new_frame");
        fd_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (frame_done)
                fd_cnt++;
        end
        check("frame_done_per_frame", fd_cnt, 1);

        cfg_write(2, 30, 20, 0, 23, 24'hFF00FF, 0);
        cfg_write(3, 31, 31, 23, 23, 24'h00FFFF, 0);
        wait_until(HA, VA - 1);
        pulse_commit();
        check("coincident_pending", commit_pending, 1'b1);
        expect_px(25, 3, BG, "coincident_wait_bg");
        cfg_layer = 2'd3;
        cfg_color = 24'hABCDEF;
        cfg_valid = 1'b1;
        pulse_commit();
        cfg_valid = 1'b0;
        expect_px(31, 23, BG, "coincident_not_yet");
        expect_px(25, 3, BG, "inverted_x_never");
        expect_px(31, 22, BG, "last_px_above");
        expect_px(30, 23, BG, "last_px_left");
        expect_px(31, 23, 24'h00FFFF, "last_px_hit");
        check("second_commit_ignored", commit_pending, 1'b0);
        check("ready_back", cfg_ready, 1'b1);

        wait_until(5, 2);
        cfg_write(0, 0, 31, 0, 23, 24'hFFFFFF, 1);
        wait_until(5, 12);
        reset = 1'b1;
        #1;
        check("rst_pending_lost", commit_pending, 1'b0);
        check("rst_ready", cfg_ready, 1'b1);
        tick();
        tick();
        reset = 1'b0;
        expect_px(0, 0, BG, "rst_frame_bg0");
        expect_px(15, 15, BG, "rst_frame_bg1");
        expect_px(31, 23, BG, "rst_frame_bg2");
        check("rst_no_pending", commit_pending, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/vga_layer_scheduler.md
# vga_layer_scheduler

Generates the 24-bit `rgb_color` stream for the VGA driver (640x480 at 60 Hz) by compositing up to `NUM_LAYERS` solid rectangles over a background colour. It tracks the pixel position from the driver's `VGA_BLANK_N` and `VGA_VS` outputs. Game logic programs layers into a shadow bank through a valid/ready handshake and requests a commit. The shadow bank is copied to the active bank only at vertical-blank entry, so a frame is never torn.

## Interface
- `NUM_LAYERS`, default 4: number of rectangle layers. Layer 0 has the highest priority.
- `H_ACTIVE`, default 640: visible pixels per line.
- `V_ACTIVE`, default 480: visible lines per frame.
- `BG_COLOR`, default 24'h000000: colour used where no layer hits.
- `VGA_CLK`  in  1: pixel clock; sole clock.
- `reset`  in  1: asynchronous, active-high reset.
- `VGA_BLANK_N`  in  1: from driver; high during visible pixels.
- `VGA_VS`  in  1: from driver; active-low vertical sync.
- `cfg_valid`  in  1: shadow write request.
- `cfg_ready`  out  1: shadow write accepted when high together with `cfg_valid`.
- `cfg_layer`  in  $clog2(NUM_LAYERS): target layer.
- `cfg_x0`, `cfg_x1`  in  10 each: inclusive horizontal bounds.
- `cfg_y0`, `cfg_y1`  in  10 each: inclusive vertical bounds.
- `cfg_color`  in  24: layer colour, laid out {R,G,B}.
- `cfg_enable`  in  1: layer enable.
- `commit`  in  1: single-cycle pulse requesting a shadow-to-active copy.
- `commit_pending`  out  1: a commit is waiting for vblank.
- `frame_done`  out  1: one-cycle pulse at vblank entry.
- `pix_x`  out  10: current column.
- `pix_y`  out  10: current line.
- `rgb_color`  out  24: to the driver's `rgb_color` input.

## Operation
- **Position counters:**
  - `pix_x` <= 0 while `VGA_BLANK_N` is low.
  - `pix_x` <= `pix_x`+1 while `VGA_BLANK_N` is high, saturating at `H_ACTIVE`-1.
  - `pix_y` <= `pix_y`+1 on each `VGA_BLANK_N` falling edge, using a registered previous value.
  - `pix_y` <= 0 whenever `VGA_VS` is low. This has priority over the increment.
- **Vblank entry:** a `VGA_BLANK_N` falling edge while `pix_y` == `V_ACTIVE`-1.
- **Layer hit:** the layer is enabled and `x0`<=`pix_x`<=`x1` and `y0`<=`pix_y`<=`y1`, compared unsigned. If `x0`>`x1` or `y0`>`y1`, the layer never hits.
- **Compositing:**
  - The colour is taken from the lowest-index hit layer, otherwise `BG_COLOR`.
  - While `VGA_BLANK_N` is low, `rgb_color` is forced to 0.
- **Controller FSM** (three states):
  - **OPEN:** `cfg_ready`=1. A handshake writes all `cfg_*` fields into shadow[`cfg_layer`]. `commit` -> PENDING.
  - **PENDING:** `cfg_ready`=0 and `commit_pending`=1. Vblank entry -> COPY. A further `commit` is ignored.
  - **COPY:** one cycle. Active <= shadow, `commit_pending` <= 0, then -> OPEN.
- **`frame_done`:** pulses on every vblank entry, whether or not a commit is pending. A frame with no commit keeps the previous active bank.
- **Simultaneous events:**
  - Handshake and `commit` in the same OPEN cycle: the write lands in shadow and is included in the commit.
  - `commit` in the same cycle as vblank entry: the copy happens at the next vblank entry, not this one.
  - `cfg_layer` >= `NUM_LAYERS`: the write is accepted and discarded.
- **Reset** (asynchronous, at any time, including mid-frame or in PENDING):
  - FSM -> OPEN.
  - Both banks cleared: all layers disabled, all fields 0.
  - Counters 0.
  - Output reset values: `rgb_color`=0, `cfg_ready`=1, `commit_pending`=0, `frame_done`=0, `pix_x`=0, `pix_y`=0.
  - A pending commit is lost.

## Timing
- `rgb_color` is registered with 1-cycle latency. The colour for pixel (x,y) appears the cycle after `pix_x`/`pix_y` show (x,y).
- `pix_x`/`pix_y` are registered and update one cycle after the `VGA_BLANK_N` edge that causes the change.
- `frame_done` and the transition into COPY occur the cycle after vblank entry is detected.
- Active-bank contents change the cycle after COPY. That is always during vertical blank, at least 44 lines before the next visible pixel.
- `cfg_ready` drops the cycle after `commit` is sampled and rises the cycle after COPY.
- Shadow writes take effect on the cycle after the handshake.

## Test plan
- **Reset state:** assert `reset` mid-line, then release -> all outputs at reset values; the first line after `VGA_VS` low shows `rgb_color`=`BG_COLOR` on visible pixels and 0 in blanking.
- **Single layer:** program layer 0 = (100,50)-(199,149), colour 24'hFF0000, enabled; commit -> `commit_pending` high until the next vblank; the following frame shows 24'hFF0000 exactly at x 100..199, y 50..149, and `BG_COLOR` elsewhere.
- **Priority:** layer 0 = (0,0)-(9,9) 24'h00FF00 and layer 1 = (5,5)-(20,20) 24'h0000FF -> pixel (7,7) = 24'h00FF00, pixel (15,15) = 24'h0000FF.
- **Tear-free update:** commit a new colour mid-frame -> the current frame is unchanged; the new colour appears from the next frame; `frame_done` pulses once per frame; `cfg_ready`=0 while pending.
- **Boundaries:** a layer with `x0`=300 > `x1`=200 never hits; a layer at (639,479)-(639,479) colours only the last pixel; `commit` coincident with vblank entry is applied one frame later; a second `commit` while pending is ignored.
- **Reset mid-commit:** reset while PENDING -> `commit_pending`=0, all layers disabled, next frame is all `BG_COLOR`.
